// File: rtl/booth_mac_acc_if.sv
// booth_mac_acc_if: configuration, product and result signals of the Booth MAC accumulator
interface booth_mac_acc_if #(
    parameter int LENGTH  = 32,
    parameter int ACC_EXT = 8,
    parameter int CNT_W   = 8
);
    localparam int ACC_W = 2 * LENGTH + ACC_EXT;
    logic                  cfg_load;
    logic [CNT_W-1:0]      cfg_len;
    logic                  cfg_ready;
    logic                  mul_done;
    logic [2*LENGTH-1:0]   mul_p;
    logic                  acc_valid;
    logic                  acc_ready;
    logic [ACC_W-1:0]      acc_data;
    logic [CNT_W-1:0]      acc_cnt;
    logic                  ovf;
    logic                  err_drop;
    modport master (
        output cfg_load, cfg_len, mul_done, mul_p, acc_ready,
        input  cfg_ready, acc_valid, acc_data, acc_cnt, ovf, err_drop
    );
    modport slave (
        input  cfg_load, cfg_len, mul_done, mul_p, acc_ready,
        output cfg_ready, acc_valid, acc_data, acc_cnt, ovf, err_drop
    );
endinterface

// File: rtl/booth_mac_acc.sv
// booth_mac_acc: sums a programmed number of multiplier products into a widened accumulator
module booth_mac_acc #(
    parameter int LENGTH       = 32,
    parameter int ACC_EXT      = 8,
    parameter int CNT_W        = 8,
    parameter bit UNSIGNED_ACC = 1'b1
) (
    input logic            clk,
    input logic            rst,
    booth_mac_acc_if.slave bus
);
    localparam int P_W   = 2 * LENGTH;
    localparam int ACC_W = P_W + ACC_EXT;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t           state, state_nx, load_st;
    logic [CNT_W-1:0] len_q, cnt_nx;
    logic             load, take, hs, ovf_add;
    logic [ACC_W-1:0] addend;
    logic [ACC_W:0]   sum;
    assign hs      = state == DONE && bus.acc_ready;
    assign load    = bus.cfg_load && bus.cfg_ready;
    assign take    = state == ACC && bus.mul_done;
    assign load_st = bus.cfg_len == '0 ? DONE : ACC;
    assign addend  = {{ACC_EXT{bus.mul_p[P_W-1] & ~UNSIGNED_ACC}}, bus.mul_p};
    assign sum     = {1'b0, bus.acc_data} + {1'b0, addend};
    assign cnt_nx  = bus.acc_cnt + 1'b1;
    assign ovf_add = UNSIGNED_ACC ? sum[ACC_W]
                   : (bus.acc_data[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != addend[ACC_W-1]);
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next state: a load (from IDLE or a DONE handshake) wins, then run completion, then release
    always_comb begin
        state_nx = load ? load_st
                 : (take && cnt_nx == len_q) ? DONE
                 : hs ? IDLE
                 : state;
    end
    // cfg_ready is open in IDLE, and in DONE only while the sum is being taken
    always_comb begin
        bus.cfg_ready = state == IDLE || hs;
    end
    // accumulator, counters and sticky flags; a dropped product outranks the load clear
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.acc_valid <= 1'b0;
            bus.acc_data  <= '0;
            bus.acc_cnt   <= '0;
            bus.ovf       <= 1'b0;
            bus.err_drop  <= 1'b0;
            len_q         <= '0;
        end else begin
            bus.acc_valid <= state_nx == DONE;
            bus.err_drop  <= (bus.mul_done && state != ACC) || (bus.err_drop && !load);
            if (load) begin
                bus.acc_data <= '0;
                bus.acc_cnt  <= '0;
                bus.ovf      <= 1'b0;
                len_q        <= bus.cfg_len;
            end else if (take) begin
                bus.acc_data <= sum[ACC_W-1:0];
                bus.acc_cnt  <= cnt_nx;
                bus.ovf      <= bus.ovf | ovf_add;
            end
        end
    end
endmodule

// File: tb/tb_booth_mac_acc.sv
// tb_booth_mac_acc: three accumulator flavours driven in lockstep and checked against an arithmetic model
module tb_booth_mac_acc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 1'b0, mul_done = 1'b0, acc_ready = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic [63:0] mul_p = '0;
    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    booth_mac_acc_if #(.ACC_EXT(8)) b0 ();
    booth_mac_acc_if #(.ACC_EXT(1)) b1 ();
    booth_mac_acc_if #(.ACC_EXT(8)) b2 ();

    assign b0.cfg_load = cfg_load; assign b0.cfg_len = cfg_len; assign b0.mul_done = mul_done;
    assign b0.mul_p = mul_p;       assign b0.acc_ready = acc_ready;
    assign b1.cfg_load = cfg_load; assign b1.cfg_len = cfg_len; assign b1.mul_done = mul_done;
    assign b1.mul_p = mul_p;       assign b1.acc_ready = acc_ready;
    assign b2.cfg_load = cfg_load; assign b2.cfg_len = cfg_len; assign b2.mul_done = mul_done;
    assign b2.mul_p = mul_p;       assign b2.acc_ready = acc_ready;

    booth_mac_acc #(.ACC_EXT(8), .UNSIGNED_ACC(1'b1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    booth_mac_acc #(.ACC_EXT(1), .UNSIGNED_ACC(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    booth_mac_acc #(.ACC_EXT(8), .UNSIGNED_ACC(1'b0)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    logic [2:0]  o_valid, o_ready, o_ovf, o_drop;
    logic [79:0] o_data [3];
    logic [7:0]  o_cnt [3];
    assign o_valid = {b2.acc_valid, b1.acc_valid, b0.acc_valid};
    assign o_ready = {b2.cfg_ready, b1.cfg_ready, b0.cfg_ready};
    assign o_ovf   = {b2.ovf, b1.ovf, b0.ovf};
    assign o_drop  = {b2.err_drop, b1.err_drop, b0.err_drop};
    assign o_data[0] = 80'(b0.acc_data);
    assign o_data[1] = 80'(b1.acc_data);
    assign o_data[2] = 80'(b2.acc_data);
    assign o_cnt[0] = b0.acc_cnt;
    assign o_cnt[1] = b1.acc_cnt;
    assign o_cnt[2] = b2.acc_cnt;

    // model: per instance, a run in progress, a finished sum awaiting pickup, and plain integer sums
    int          m_w [3]   = '{72, 65, 72};
    bit          m_uns [3] = '{1'b1, 1'b1, 1'b0};
    bit          m_run [3], m_fin [3], m_ovf [3], m_drop [3];
    int          m_len [3], m_cnt [3];
    logic [79:0] m_sum [3];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic madd(input int i);
        int                 w;
        logic [79:0]        full, mask;
        logic signed [79:0] a, b, r, lim;
        w    = m_w[i];
        mask = (80'd1 << w) - 80'd1;
        if (m_uns[i]) begin
            full = m_sum[i] + {16'd0, mul_p};
            if ((full >> w) != 80'd0) m_ovf[i] = 1'b1;
            m_sum[i] = full & mask;
        end else begin
            a = m_sum[i];
            if (m_sum[i][w-1]) a = a - (80'sd1 <<< w);
            b   = {{16{mul_p[63]}}, mul_p};
            r   = a + b;
            lim = 80'sd1 <<< (w - 1);
            if (r >= lim || r < -lim) m_ovf[i] = 1'b1;
            m_sum[i] = r & mask;
        end
    endtask

    function automatic bit m_rdy(input int i);
        return (!m_run[i] && !m_fin[i]) || (m_fin[i] && acc_ready);
    endfunction

    always @(posedge clk) begin
        if (rst) chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_run[i] = 0; m_fin[i] = 0; m_ovf[i] = 0; m_drop[i] = 0; m_cnt[i] = 0; m_sum[i] = '0;
            end else begin
                bit was_run, rdy;
                was_run = m_run[i];
                rdy     = m_rdy(i);
                if (m_run[i] && mul_done) begin
                    madd(i);
                    m_cnt[i]++;
                    if (m_cnt[i] == m_len[i]) begin m_run[i] = 0; m_fin[i] = 1; end
                end else if (cfg_load && rdy) begin
                    m_sum[i] = '0; m_cnt[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
                    m_len[i] = int'(cfg_len);
                    m_run[i] = cfg_len != 0;
                    m_fin[i] = cfg_len == 0;
                end else if (m_fin[i] && acc_ready) begin
                    m_fin[i] = 0;
                end
                if (mul_done && !was_run) m_drop[i] = 1;
            end
        end
    end

    // every-cycle comparison of all outputs of all three instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d acc_valid", i), 80'(o_valid[i]), 80'(m_fin[i]));
                chk($sformatf("u%0d acc_data", i), o_data[i], m_sum[i]);
                chk($sformatf("u%0d acc_cnt", i), 80'(o_cnt[i]), 80'(m_cnt[i]));
                chk($sformatf("u%0d ovf", i), 80'(o_ovf[i]), 80'(m_ovf[i]));
                chk($sformatf("u%0d err_drop", i), 80'(o_drop[i]), 80'(m_drop[i]));
                chk($sformatf("u%0d cfg_ready", i), 80'(o_ready[i]), 80'(m_rdy(i)));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] n);
        cfg_load = 1'b1; cfg_len = n; cyc(); cfg_load = 1'b0;
    endtask

    task automatic prod(input logic [63:0] p);
        mul_done = 1'b1; mul_p = p; cyc(); mul_done = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        rst = 1'b0;
        chk("reset valid", 80'(o_valid[0]), 80'd0);
        chk("reset data", o_data[0], 80'd0);
        chk("reset ready", 80'(o_ready[0]), 80'd1);

        load(8'd3); prod(64'd10); prod(64'd20); prod(64'd30);
        chk("sum3 valid", 80'(o_valid[0]), 80'd1);
        chk("sum3 data", o_data[0], 80'd60);
        chk("sum3 cnt", 80'(o_cnt[0]), 80'd3);
        chk("sum3 ovf", 80'(o_ovf[0]), 80'd0);
        chk("sum3 drop", 80'(o_drop[0]), 80'd0);

        cyc(); cyc(); prod(64'd7); cyc(); cyc();
        chk("bp data", o_data[0], 80'd60);
        chk("bp valid", 80'(o_valid[0]), 80'd1);
        chk("bp drop", 80'(o_drop[0]), 80'd1);
        acc_ready = 1'b1; cyc(); acc_ready = 1'b0;
        chk("bp release", 80'(o_valid[0]), 80'd0);

        load(8'd3);
        repeat (3) prod(64'hFFFF_FFFF_FFFF_FFFF);
        chk("uovf data", o_data[1], 80'hFFFF_FFFF_FFFF_FFFD);
        chk("uovf flag", 80'(o_ovf[1]), 80'd1);
        chk("wide data", o_data[0], 80'h2_FFFF_FFFF_FFFF_FFFD);
        chk("wide ovf", 80'(o_ovf[0]), 80'd0);
        chk("sneg3 data", o_data[2], 80'hFF_FFFF_FFFF_FFFF_FFFD);
        acc_ready = 1'b1; cyc(); acc_ready = 1'b0;

        load(8'd2); prod(64'hFFFF_FFFF_FFFF_FFFB); prod(64'd3);
        chk("signed data", o_data[2], 80'hFF_FFFF_FFFF_FFFF_FFFE);
        chk("signed ovf", 80'(o_ovf[2]), 80'd0);

        acc_ready = 1'b1; cfg_load = 1'b1; cfg_len = 8'd0; cyc();
        chk("zero valid", 80'(o_valid[0]), 80'd1);
        chk("zero data", o_data[0], 80'd0);
        chk("zero cnt", 80'(o_cnt[0]), 80'd0);
        cfg_len = 8'd2; cyc(); cfg_load = 1'b0; acc_ready = 1'b0;
        chk("direct acc valid", 80'(o_valid[0]), 80'd0);
        chk("direct acc ready", 80'(o_ready[0]), 80'd0);
        cfg_load = 1'b1; cfg_len = 8'd9; prod(64'd1); cfg_load = 1'b0; prod(64'd2);
        chk("direct sum", o_data[0], 80'd3);
        chk("direct valid", 80'(o_valid[0]), 80'd1);
        chk("direct cnt", 80'(o_cnt[0]), 80'd2);

        acc_ready = 1'b1; cyc(); acc_ready = 1'b0;
        load(8'd3); prod(64'd9);
        chk("partial", o_data[0], 80'd9);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("mid rst data", o_data[0], 80'd0);
        chk("mid rst cnt", 80'(o_cnt[0]), 80'd0);
        chk("mid rst valid", 80'(o_valid[0]), 80'd0);
        chk("mid rst ready", 80'(o_ready[0]), 80'd1);
        prod(64'd5);
        chk("idle drop", 80'(o_drop[0]), 80'd1);
        chk("idle data", o_data[0], 80'd0);

        repeat (4000) begin
            rst       = $urandom_range(299) == 0;
            cfg_load  = $urandom_range(3) == 0;
            cfg_len   = 8'($urandom_range(7));
            mul_done  = $urandom_range(3) != 0;
            acc_ready = $urandom_range(1) == 1;
            case ($urandom_range(3))
                0: mul_p = 64'($urandom_range(100));
                1: mul_p = {$urandom, $urandom};
                2: mul_p = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(50));
                default: mul_p = {1'b0, 31'($urandom), $urandom};
            endcase
            cyc();
        end
        rst = 1'b0; cfg_load = 1'b0; mul_done = 1'b0; acc_ready = 1'b0;
        cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
